// File: rtl/ram_bus_16_if.sv
// Request/acknowledge bus between the CPU bus unit and the 16-bit byte-lane RAM.
interface ram_bus_16_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic                  byte_op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           wdata;
  logic                  ack;
  logic [15:0]           rdata;
  logic                  odd_err;
  logic                  nxm_err;

  modport master (
    output req, we, byte_op, addr, wdata,
    input  ack, rdata, odd_err, nxm_err
  );

  modport slave (
    input  req, we, byte_op, addr, wdata,
    output ack, rdata, odd_err, nxm_err
  );
endinterface

// File: rtl/ram_bus_16.sv
// 16-bit byte-lane RAM behind a req/ack handshake with programmable wait states,
// registered read data and odd-address / non-existent-memory error pulses.
module ram_bus_16 #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MEM_WORDS   = 32768,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  ram_bus_16_if.slave bus
);
  localparam int unsigned IDX_W   = ADDR_WIDTH - 1;
  localparam int unsigned MEM_AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic                  byte_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic                  ack_q;
  logic                  odd_q;
  logic                  nxm_q;
  logic [15:0]           rdata_q;

  logic [7:0] mem_lo [MEM_WORDS];
  logic [7:0] mem_hi [MEM_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] ram_idx;
  logic              odd_hit;
  logic              nxm_hit;
  logic              ok;
  logic              commit;
  logic              wr_lo;
  logic              wr_hi;
  logic [7:0]        wlo_data;
  logic [7:0]        whi_data;
  logic [15:0]       rd_word;
  logic [15:0]       rd_data;

  // Error checks use only the latched request, so the bus may move after capture.
  always_comb begin
    idx      = addr_q[ADDR_WIDTH-1:1];
    ram_idx  = idx[MEM_AW-1:0];
    odd_hit  = !byte_q && addr_q[0];
    nxm_hit  = !odd_hit && (32'(idx) >= MEM_WORDS);
    ok       = !odd_hit && !nxm_hit;
    commit   = reset_n && (state_q == S_DONE) && ok && we_q;
    wr_lo    = commit && (!byte_q || !addr_q[0]);
    wr_hi    = commit && (!byte_q || addr_q[0]);
    wlo_data = wdata_q[7:0];
    whi_data = byte_q ? wdata_q[7:0] : wdata_q[15:8];
    rd_word  = {mem_hi[ram_idx], mem_lo[ram_idx]};
    rd_data  = byte_q ? {8'h00, (addr_q[0] ? rd_word[15:8] : rd_word[7:0])} : rd_word;
  end

  always_ff @(posedge clk) begin
    if (wr_lo) mem_lo[ram_idx] <= wlo_data;
    if (wr_hi) mem_hi[ram_idx] <= whi_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      odd_q   <= 1'b0;
      nxm_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      odd_q <= 1'b0;
      nxm_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            byte_q  <= bus.byte_op;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            if (WAIT_STATES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= WS_INIT;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_DONE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_DONE: begin
          ack_q <= ok;
          odd_q <= odd_hit;
          nxm_q <= nxm_hit;
          if (ok && !we_q) rdata_q <= rd_data;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack     = ack_q;
  assign bus.odd_err = odd_q;
  assign bus.nxm_err = nxm_q;
  assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_ram_bus_16.sv
// Directed bench: dut_a (no wait states, 4096 words) and dut_b (3 wait states) share inputs.
module tb_ram_bus_16;
  logic        clk;
  logic        reset_n;
  logic        req;
  logic        we;
  logic        byte_op;
  logic [15:0] addr;
  logic [15:0] wdata;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] P_ACK = 3'b100;
  localparam logic [2:0] P_ODD = 3'b010;
  localparam logic [2:0] P_NXM = 3'b001;

  ram_bus_16_if #(.ADDR_WIDTH(16)) bus_a ();
  ram_bus_16_if #(.ADDR_WIDTH(16)) bus_b ();

  assign bus_a.req = req;  assign bus_a.we = we;  assign bus_a.byte_op = byte_op;
  assign bus_a.addr = addr; assign bus_a.wdata = wdata;
  assign bus_b.req = req;  assign bus_b.we = we;  assign bus_b.byte_op = byte_op;
  assign bus_b.addr = addr; assign bus_b.wdata = wdata;

  ram_bus_16 #(.ADDR_WIDTH(16), .MEM_WORDS(4096), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a));
  ram_bus_16 #(.ADDR_WIDTH(16), .MEM_WORDS(32768), .WAIT_STATES(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b));

  logic [2:0] pa;
  logic [2:0] pb;
  assign pa = {bus_a.ack, bus_a.odd_err, bus_a.nxm_err};
  assign pb = {bus_b.ack, bus_b.odd_err, bus_b.nxm_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic        bop;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  exp_pulse;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = 1'b0; we = 1'b0; byte_op = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One access; lat counts posedges after the capture edge until the pulse.
  task automatic run_access(input bit sel_b, input logic w, input logic b,
                            input logic [15:0] a, input logic [15:0] d,
                            output logic [2:0] pulse, output int lat,
                            output logic [2:0] after, output logic [15:0] rd);
    @(negedge clk);
    req = 1'b1; we = w; byte_op = b; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); byte_op = 1'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);
    pulse = '0; lat = -1;
    rd = sel_b ? bus_b.rdata : bus_a.rdata;
    for (int k = 0; k <= 20; k++) begin
      if ((sel_b ? pb : pa) != 3'b000) begin
        pulse = sel_b ? pb : pa;
        lat   = k;
        rd    = sel_b ? bus_b.rdata : bus_a.rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    after = sel_b ? pb : pa;
  endtask

  task automatic access_check(input string tag, input bit sel_b, input logic w, input logic b,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic [2:0] ep, input int elat, input logic [15:0] erd);
    logic [2:0]  p;
    logic [2:0]  af;
    logic [15:0] r;
    int          l;
    run_access(sel_b, w, b, a, d, p, l, af, r);
    check({tag, " pulse"}, 32'(p), 32'(ep));
    check({tag, " latency"}, 32'(l), 32'(elat));
    check({tag, " rdata"}, 32'(r), 32'(erd));
    check({tag, " one-cycle"}, 32'(af), 32'd0);
  endtask

  initial begin
    logic [31:0] mask;
    logic [15:0] rd_at_ack;

    vecs[0]  = '{1'b1, 1'b0, 16'h0200, 16'hA72E, P_ACK, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, P_ACK, 16'hA72E};
    vecs[2]  = '{1'b1, 1'b1, 16'h0201, 16'h00FF, P_ACK, 16'hA72E};
    vecs[3]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, P_ACK, 16'hFF2E};
    vecs[4]  = '{1'b0, 1'b1, 16'h0201, 16'h0000, P_ACK, 16'h00FF};
    vecs[5]  = '{1'b0, 1'b1, 16'h0200, 16'h0000, P_ACK, 16'h002E};
    vecs[6]  = '{1'b1, 1'b0, 16'h0202, 16'h1234, P_ACK, 16'h002E};
    vecs[7]  = '{1'b1, 1'b0, 16'h0203, 16'hBEEF, P_ODD, 16'h002E};
    vecs[8]  = '{1'b0, 1'b0, 16'h0202, 16'h0000, P_ACK, 16'h1234};
    vecs[9]  = '{1'b1, 1'b1, 16'h0203, 16'hCDAB, P_ACK, 16'h1234};
    vecs[10] = '{1'b0, 1'b0, 16'h0202, 16'h0000, P_ACK, 16'hAB34};
    vecs[11] = '{1'b0, 1'b0, 16'h0203, 16'h0000, P_ODD, 16'hAB34};
    vecs[12] = '{1'b0, 1'b0, 16'h2000, 16'h0000, P_NXM, 16'hAB34};
    vecs[13] = '{1'b0, 1'b1, 16'h2001, 16'h0000, P_NXM, 16'hAB34};
    vecs[14] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, P_ODD, 16'hAB34};
    vecs[15] = '{1'b1, 1'b0, 16'h1FFE, 16'h5A5A, P_ACK, 16'hAB34};
    vecs[16] = '{1'b0, 1'b0, 16'h1FFE, 16'h0000, P_ACK, 16'h5A5A};
    vecs[17] = '{1'b1, 1'b0, 16'h0000, 16'h0F0F, P_ACK, 16'h5A5A};
    vecs[18] = '{1'b1, 1'b0, 16'h2000, 16'h1111, P_NXM, 16'h5A5A};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 16'h0000, P_ACK, 16'h0F0F};
    vecs[20] = '{1'b1, 1'b1, 16'h0000, 16'h77C3, P_ACK, 16'h0F0F};
    vecs[21] = '{1'b0, 1'b0, 16'h0000, 16'h0000, P_ACK, 16'h0FC3};

    do_reset();
    @(negedge clk);
    check("reset a", {13'd0, pa, bus_a.rdata}, 32'd0);
    check("reset b", {13'd0, pb, bus_b.rdata}, 32'd0);

    for (int i = 0; i < 22; i++)
      access_check($sformatf("a v%0d", i), 1'b0, vecs[i].we, vecs[i].bop,
                   vecs[i].addr, vecs[i].wdata, vecs[i].exp_pulse, 1, vecs[i].exp_rdata);

    do_reset();
    @(negedge clk);
    check("reset b2", {13'd0, pb, bus_b.rdata}, 32'd0);
    access_check("b wr", 1'b1, 1'b1, 1'b0, 16'h0100, 16'hC0DE, P_ACK, 4, 16'h0000);
    access_check("b rd", 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, P_ACK, 4, 16'hC0DE);
    access_check("b odd", 1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000, P_ODD, 4, 16'hC0DE);

    // A write request pulsed while dut_b is in WAIT must be ignored.
    @(negedge clk);
    req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 16'h0100; wdata = 16'h0000;
    @(posedge clk);
    mask = '0; rd_at_ack = '0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (bus_b.ack) begin mask = mask | (32'd1 << k); rd_at_ack = bus_b.rdata; end
      if (pb[1:0] != 2'b00) mask = mask | 32'h8000_0000;
      if (k == 0) req = 1'b0;
      if (k == 1) begin req = 1'b1; we = 1'b1; addr = 16'h0100; wdata = 16'h9999; end
      if (k == 2) begin req = 1'b0; we = 1'b0; end
      @(posedge clk);
    end
    check("b toggle acks", mask, 32'h0000_0010);
    check("b toggle rdata", 32'(rd_at_ack), 32'h0000_C0DE);
    access_check("b rd after toggle", 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, P_ACK, 4, 16'hC0DE);

    // req held high: captures on cycles 0 and 5, acks on 4 and 9.
    @(negedge clk);
    req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 16'h0100;
    @(posedge clk);
    mask = '0;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (bus_b.ack) mask = mask | (32'd1 << k);
      if (pb[1:0] != 2'b00) mask = mask | 32'h8000_0000;
      if (k == 9) req = 1'b0;
      @(posedge clk);
    end
    check("b back-to-back acks", mask, 32'h0000_0210);

    // Reset during WAIT of a write aborts it.
    @(negedge clk);
    req = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 16'h0100; wdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b reset mid-access outputs", {13'd0, pb, bus_b.rdata}, 32'd0);
    reset_n = 1'b1;
    mask = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pb != 3'b000) mask = mask | (32'd1 << k);
    end
    check("b no pulse after abort", mask, 32'd0);
    access_check("b rd after abort", 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, P_ACK, 4, 16'hC0DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
